// File: rtl/znz_encoder.sv
// Zero/nonzero run-length encoder: zeros become '0'+(run-1) symbols, nonzeros become '1' plus a forwarded value.
// Latency: nonzero value on nz_data_o one cycle after acceptance; a ZNZ word appears as soon as DATA_W bits are packed.
// Backpressure: rdy_o drops when the buffer lacks room for a worst-case symbol pair, in FLUSH, or while nz is stalled.
// Optional: define ZNZ_ENCODER_STATS_EN to add the n_nonzero_o / n_zero_o word counters.
`timescale 1ns/1ps
module znz_encoder #(
  parameter int DATA_W       = 8,
  parameter int LOG_MAX_ZRUN = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] nz_data_o,
  output logic              nz_vld_o,
  input  logic              nz_rdy_i,
  output logic [DATA_W-1:0] znz_o,
  output logic              znz_last_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i
`ifdef ZNZ_ENCODER_STATS_EN
  ,
  output logic [31:0]       n_nonzero_o,
  output logic [31:0]       n_zero_o
`endif
);

  localparam int BUF_W  = 2 * DATA_W;
  localparam int SYM_W  = LOG_MAX_ZRUN + 2;   // worst case: run-close symbol followed by '1'
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0]       RDY_LIMIT = FILL_W'(BUF_W - SYM_W);
  localparam logic [FILL_W-1:0]       WORD_FILL = FILL_W'(DATA_W);
  localparam logic [LOG_MAX_ZRUN-1:0] RUN_ONE   = LOG_MAX_ZRUN'(1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [BUF_W-1:0]        buf_q, buf_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [LOG_MAX_ZRUN-1:0] run_q, run_d;     // zeros seen in the open run (0..MAX_ZRUN-1)
  logic [DATA_W-1:0]       nz_data_q, nz_data_d;
  logic                    nz_vld_q, nz_vld_d;

  logic                    in_xfer, znz_xfer, is_nz;
  logic [SYM_W-1:0]        sym;               // left-justified, unused LSBs zero
  logic [FILL_W-1:0]       sym_len;
  logic [BUF_W-1:0]        buf_sh;
  logic [FILL_W-1:0]       fill_sh;

  assign is_nz     = (data_i != '0);
  assign in_xfer   = vld_i && rdy_o;
  assign znz_xfer  = znz_vld_o && znz_rdy_i;
  assign nz_vld_o  = nz_vld_q;
  assign nz_data_o = nz_data_q;

  // Handshake outputs: ZNZ word valid from buffer fill; input ready only with room and a free nz slot.
  always_comb begin
    znz_vld_o  = 1'b0;
    znz_last_o = 1'b0;
    if (state_q == RUN) begin
      znz_vld_o = (fill_q >= WORD_FILL);
    end else begin
      znz_vld_o  = (fill_q != '0);
      znz_last_o = (fill_q != '0) && (fill_q <= WORD_FILL);
    end
    znz_o = znz_vld_o ? buf_q[BUF_W-1 -: DATA_W] : '0;
    rdy_o = !rst_i && (state_q == RUN) && (fill_q <= RDY_LIMIT) &&
            (!nz_vld_q || nz_rdy_i);
  end

  // Symbol generation and run counter update for the accepted word.
  always_comb begin
    sym     = '0;
    sym_len = '0;
    run_d   = run_q;
    if (in_xfer) begin
      if (is_nz) begin
        if (run_q != '0) begin
          sym     = {1'b0, run_q - RUN_ONE, 1'b1};
          sym_len = FILL_W'(SYM_W);
        end else begin
          sym     = {1'b1, {(SYM_W-1){1'b0}}};
          sym_len = FILL_W'(1);
        end
        run_d = '0;
      end else if ((&run_q) || last_i) begin
        // this zero completes a run of run_q+1, so the stored count is already n-1
        sym     = {1'b0, run_q, 1'b0};
        sym_len = FILL_W'(SYM_W - 1);
        run_d   = '0;
      end else begin
        run_d = run_q + RUN_ONE;
      end
    end
  end

  // Bit buffer: drain a word on transfer, then append the new symbol behind the remaining bits.
  always_comb begin
    buf_sh  = buf_q;
    fill_sh = fill_q;
    if (znz_xfer) begin
      buf_sh  = buf_q << DATA_W;
      fill_sh = (fill_q > WORD_FILL) ? (fill_q - WORD_FILL) : '0;
    end
    buf_d   = buf_sh | ({sym, {(BUF_W-SYM_W){1'b0}}} >> fill_sh);
    fill_d  = fill_sh + sym_len;
    state_d = state_q;
    if (state_q == RUN) begin
      if (in_xfer && last_i) state_d = FLUSH;
    end else if (znz_xfer && znz_last_o) begin
      state_d = RUN;
      buf_d   = '0;
      fill_d  = '0;
    end
  end

  // Nonzero value register: load on accepted nonzero, clear when consumed.
  always_comb begin
    nz_vld_d  = nz_vld_q;
    nz_data_d = nz_data_q;
    if (nz_vld_q && nz_rdy_i) nz_vld_d = 1'b0;
    if (in_xfer && is_nz) begin
      nz_vld_d  = 1'b1;
      nz_data_d = data_i;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      buf_q     <= '0;
      fill_q    <= '0;
      run_q     <= '0;
      nz_data_q <= '0;
      nz_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      fill_q    <= fill_d;
      run_q     <= run_d;
      nz_data_q <= nz_data_d;
      nz_vld_q  <= nz_vld_d;
    end
  end

`ifdef ZNZ_ENCODER_STATS_EN
  logic [31:0] n_nonzero_q, n_nonzero_d, n_zero_q, n_zero_d;

  // Count accepted words by class.
  always_comb begin
    n_nonzero_d = n_nonzero_q;
    n_zero_d    = n_zero_q;
    if (in_xfer && is_nz)  n_nonzero_d = n_nonzero_q + 32'd1;
    if (in_xfer && !is_nz) n_zero_d    = n_zero_q + 32'd1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_nonzero_q <= '0;
      n_zero_q    <= '0;
    end else begin
      n_nonzero_q <= n_nonzero_d;
      n_zero_q    <= n_zero_d;
    end
  end

  assign n_nonzero_o = n_nonzero_q;
  assign n_zero_o    = n_zero_q;
`endif

endmodule

// File: tb/tb_znz_encoder.sv
// Bench for znz_encoder: bit-queue reference model, per-cycle output compare, directed blocks.
// Latency: not applicable.
// Backpressure: output readies are held low or toggled in selected blocks.
`timescale 1ns/1ps
module tb_znz_encoder;
  localparam int DW   = 8;
  localparam int LZ   = 4;
  localparam int MAXZ = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [DW-1:0] data_i;
  logic          last_i, vld_i, rdy_o;
  logic [DW-1:0] nz_data_o;
  logic          nz_vld_o, nz_rdy_i;
  logic [DW-1:0] znz_o;
  logic          znz_last_o, znz_vld_o, znz_rdy_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] blk[$];
  logic [7:0] exp_nz[$];
  logic [8:0] exp_znz[$];
  bit         bp_on;

  znz_encoder #(.DATA_W(DW), .LOG_MAX_ZRUN(LZ)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .last_i(last_i),
    .vld_i(vld_i), .rdy_o(rdy_o), .nz_data_o(nz_data_o), .nz_vld_o(nz_vld_o),
    .nz_rdy_i(nz_rdy_i), .znz_o(znz_o), .znz_last_o(znz_last_o),
    .znz_vld_o(znz_vld_o), .znz_rdy_i(znz_rdy_i)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: build the block's symbol bitstream, pad, cut into words.
  task automatic model_block();
    bit bits[$];
    int run = 0;
    logic [LZ-1:0] code;
    logic [7:0] v;
    int nw;
    for (int i = 0; i < blk.size(); i++) begin
      if (blk[i] != 8'h00) begin
        if (run > 0) begin
          code = LZ'(run - 1);
          bits.push_back(1'b0);
          for (int b = LZ-1; b >= 0; b--) bits.push_back(code[b]);
        end
        run = 0;
        bits.push_back(1'b1);
        exp_nz.push_back(blk[i]);
      end else begin
        run++;
        if (run == MAXZ || i == blk.size()-1) begin
          code = LZ'(run - 1);
          bits.push_back(1'b0);
          for (int b = LZ-1; b >= 0; b--) bits.push_back(code[b]);
          run = 0;
        end
      end
    end
    while (bits.size() % DW != 0) bits.push_back(1'b0);
    nw = bits.size() / DW;
    for (int w = 0; w < nw; w++) begin
      v = 8'h00;
      for (int b = 0; b < DW; b++) v = {v[6:0], bits[w*DW+b]};
      exp_znz.push_back({(w == nw-1) ? 1'b1 : 1'b0, v});
    end
  endtask

  // Present one word and hold it until accepted; returns at a falling edge.
  task automatic send(input logic [7:0] d, input logic l);
    int t = 0;
    bit done = 0;
    logic ok;
    vld_i = 1'b1; data_i = d; last_i = l;
    while (!done) begin
      #1;
      ok = rdy_o;
      @(posedge clk_i);
      if (ok) done = 1;
      else begin
        @(negedge clk_i);
        t++;
        if (t > 400) begin
          checks++; errors++;
          $display("FAIL send_timeout: word 0x%0h not accepted, required acceptance", d);
          done = 1;
        end
      end
    end
    @(negedge clk_i);
  endtask

  task automatic play_block();
    for (int i = 0; i < blk.size(); i++) send(blk[i], (i == blk.size()-1));
    vld_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while ((exp_nz.size() != 0 || exp_znz.size() != 0) && t < 400) begin
      @(negedge clk_i); t++;
    end
    repeat (3) @(negedge clk_i);
    chk({nm, "_nz_left"}, 32'(exp_nz.size()), 32'd0);
    chk({nm, "_znz_left"}, 32'(exp_znz.size()), 32'd0);
    #1;
    chk({nm, "_idle_znz_vld"}, 32'(znz_vld_o), 32'd0);
    chk({nm, "_idle_rdy"}, 32'(rdy_o), 32'd1);
    @(negedge clk_i);
  endtask

  // Compare process: every transfer against the model, and stability of stalled outputs.
  logic [8:0] prev_znz;
  logic [7:0] prev_nz;
  bit         prev_zv = 0, prev_nv = 0;
  always begin
    @(negedge clk_i);
    #2;
    if (rst_i) begin
      prev_zv = 0; prev_nv = 0;
    end else begin
      if (prev_zv) chk("znz_hold", 32'({znz_vld_o, znz_last_o, znz_o}), 32'({1'b1, prev_znz}));
      if (prev_nv) chk("nz_hold", 32'({nz_vld_o, nz_data_o}), 32'({1'b1, prev_nz}));
      if (znz_vld_o && znz_rdy_i) begin
        if (exp_znz.size() == 0) begin
          checks++; errors++;
          $display("FAIL znz_extra: got 0x%0h required no word", {znz_last_o, znz_o});
        end else chk("znz_word", 32'({znz_last_o, znz_o}), 32'(exp_znz.pop_front()));
        prev_zv = 0;
      end else begin
        prev_zv = znz_vld_o; prev_znz = {znz_last_o, znz_o};
      end
      if (nz_vld_o && nz_rdy_i) begin
        if (exp_nz.size() == 0) begin
          checks++; errors++;
          $display("FAIL nz_extra: got 0x%0h required no value", nz_data_o);
        end else chk("nz_value", 32'(nz_data_o), 32'(exp_nz.pop_front()));
        prev_nv = 0;
      end else begin
        prev_nv = nz_vld_o; prev_nz = nz_data_o;
      end
    end
  end

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_rdy"}, 32'(rdy_o), 32'd0);
    chk({nm, "_nz_vld"}, 32'(nz_vld_o), 32'd0);
    chk({nm, "_znz_vld"}, 32'(znz_vld_o), 32'd0);
    chk({nm, "_znz_last"}, 32'(znz_last_o), 32'd0);
    chk({nm, "_nz_data"}, 32'(nz_data_o), 32'd0);
    chk({nm, "_znz"}, 32'(znz_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; vld_i = 1'b0; data_i = '0; last_i = 1'b0;
    nz_rdy_i = 1'b1; znz_rdy_i = 1'b1; bp_on = 0;
    #3;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Two nonzeros: '11' padded.
    blk = {8'h05, 8'h03};
    model_block();
    chk("r036_nz_cnt", 32'(exp_nz.size()), 32'd2);
    chk("r036_znz", 32'(exp_znz[0]), 32'h1C0);
    play_block(); drain("r036");

    // Three zeros closed by a nonzero.
    blk = {8'h00, 8'h00, 8'h00, 8'h07};
    model_block();
    chk("r037_nz", 32'(exp_nz[0]), 32'h07);
    chk("r037_znz", 32'(exp_znz[0]), 32'h114);
    play_block(); drain("r037");

    // Maximum run coinciding with last.
    blk.delete();
    repeat (16) blk.push_back(8'h00);
    model_block();
    chk("r038_nz_cnt", 32'(exp_nz.size()), 32'd0);
    chk("r038_znz", 32'(exp_znz[0]), 32'h178);
    play_block(); drain("r038");

    // Seventeen zeros: max-run close then a run of one.
    blk.delete();
    repeat (17) blk.push_back(8'h00);
    model_block();
    chk("r039_znz_cnt", 32'(exp_znz.size()), 32'd2);
    chk("r039_znz0", 32'(exp_znz[0]), 32'h078);
    chk("r039_znz1", 32'(exp_znz[1]), 32'h100);
    play_block(); drain("r039");

    // Eight nonzeros with the nz consumer stalled.
    blk.delete();
    for (int i = 1; i <= 8; i++) blk.push_back(8'(i));
    model_block();
    chk("r040_znz", 32'(exp_znz[0]), 32'h1FF);
    chk("r040_nz_last", 32'(exp_nz[7]), 32'h08);
    nz_rdy_i = 1'b0;
    fork
      begin repeat (10) @(negedge clk_i); nz_rdy_i = 1'b1; end
      begin
        send(8'h01, 1'b0);
        #1;
        chk("r040_rdy_low", 32'(rdy_o), 32'd0);
        chk("r040_nz_held", 32'({nz_vld_o, nz_data_o}), 32'h101);
        for (int i = 2; i <= 8; i++) send(8'(i), (i == 8));
        vld_i = 1'b0; last_i = 1'b0;
      end
    join
    drain("r040");

    // Reset mid-block discards everything.
    for (int i = 1; i <= 5; i++) begin
      exp_nz.push_back(8'(i));
      send(8'(i), 1'b0);
    end
    vld_i = 1'b0;
    rst_i = 1'b1;
    #1;
    chk_reset_outputs("r041_mid");
    exp_nz.delete(); exp_znz.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    blk = {8'h05, 8'h03};
    model_block();
    chk("r041_znz", 32'(exp_znz[0]), 32'h1C0);
    play_block(); drain("r041");

    // Mixed block with a long zero run and random backpressure on both outputs.
    blk.delete();
    for (int i = 0; i < 24; i++)
      blk.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
    repeat (20) blk.push_back(8'h00);
    for (int i = 0; i < 12; i++)
      blk.push_back(($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
    model_block();
    bp_on = 1;
    fork
      begin
        while (bp_on) begin
          @(negedge clk_i);
          nz_rdy_i  = ($urandom_range(0, 3) != 0);
          znz_rdy_i = ($urandom_range(0, 2) != 0);
        end
      end
      begin play_block(); bp_on = 0; end
    join
    nz_rdy_i = 1'b1; znz_rdy_i = 1'b1;
    drain("mixed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/znz_encoder.md
ZNZ_ENCODER -- requirements
Module: znz_encoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, giving the word width of the data, nonzero-value and ZNZ streams.
REQ-002 SHALL have parameter LOG_MAX_ZRUN, default 4, giving the run-length field width; the maximum zero run MAX_ZRUN is 2**LOG_MAX_ZRUN.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have port data_i, input, DATA_W bits: uncompressed input word.
REQ-007 SHALL have port last_i, input, 1 bit: marks the final word of a block.
REQ-008 SHALL have ports vld_i (input, 1 bit) and rdy_o (output, 1 bit): input handshake.
REQ-009 SHALL have port nz_data_o, output, DATA_W bits: nonzero values, in order, for the BPC encoder.
REQ-010 SHALL have ports nz_vld_o (output, 1 bit) and nz_rdy_i (input, 1 bit): nonzero-value stream handshake.
REQ-011 SHALL have port znz_o, output, DATA_W bits: packed ZNZ bitstream word.
REQ-012 SHALL have port znz_last_o, output, 1 bit: marks the final ZNZ word of a block.
REQ-013 SHALL have ports znz_vld_o (output, 1 bit) and znz_rdy_i (input, 1 bit): ZNZ stream handshake.

Function
REQ-014 SHALL treat a transfer on any stream as occurring when vld and rdy are both high at a rising clock edge.
REQ-015 SHALL hold a valid output's data and last stable until that output transfers.
REQ-016 SHALL encode each accepted nonzero word as the 1-bit symbol '1' and forward its value on nz_data_o one cycle after acceptance.
REQ-017 SHALL count accepted zero words in a run counter and emit no symbol for them until the run closes.
REQ-018 SHALL close a zero run of length n when any of these occurs: n reaches MAX_ZRUN; a nonzero word arrives; last_i is accepted.
REQ-019 SHALL encode a closed zero run of length n as the symbol '0' followed by (n-1) on LOG_MAX_ZRUN bits, MSB first.
REQ-020 SHALL emit the closing zero-run symbol before the '1' symbol when a nonzero word closes the run.
REQ-021 SHALL pack symbols MSB-first into a 2*DATA_W-bit bit buffer with a fill count.
REQ-022 SHALL present a ZNZ word whenever fill >= DATA_W, taking the oldest DATA_W bits of the buffer.
REQ-023 SHALL drive rdy_o high only when all three hold: state is RUN; fill <= 2*DATA_W-(LOG_MAX_ZRUN+2); the nonzero output register is empty or transfers in the same cycle.
REQ-024 SHALL use a two-state FSM: RUN and FLUSH.
REQ-025 SHALL go from RUN to FLUSH when last_i is accepted, after appending that word's symbol(s).
REQ-026 SHALL, in FLUSH, emit ceil(fill/DATA_W) words, pad the final word with zeros in its LSBs, and assert znz_last_o only on that final word.
REQ-027 SHALL return from FLUSH to RUN with fill=0 and the run counter at 0 in the cycle the final word transfers.
REQ-028 SHALL allow a ZNZ word to transfer and a new symbol to be appended in the same cycle.
REQ-029 SHALL restart the run count at 0 after a MAX_ZRUN close.
REQ-030 SHALL saturate no counter, because the counter width covers all states.

Reset
REQ-031 SHALL, while rst_i is high, set the following regardless of clk_i: rdy_o=0, nz_vld_o=0, znz_vld_o=0, znz_last_o=0, nz_data_o=0, znz_o=0, fill=0, run counter=0, state=RUN.
REQ-032 SHALL, on reset asserted mid-block, discard all buffered bits and values, and after release start a fresh block.

Configuration
REQ-033 SHALL, when ZNZ_ENCODER_STATS_EN is defined, add 32-bit outputs n_nonzero_o and n_zero_o.
REQ-034 SHALL, with ZNZ_ENCODER_STATS_EN defined, increment n_nonzero_o and n_zero_o per accepted nonzero or zero word, and clear them only on reset.
REQ-035 SHALL, without ZNZ_ENCODER_STATS_EN, have neither port nor counter logic.

Verification (DATA_W=8, LOG_MAX_ZRUN=4)
REQ-036 SHALL cover: inputs 0x05, then 0x03 with last -> nz 0x05, 0x03; znz 0xC0 with last.
REQ-037 SHALL cover: three zeros, then 0x07 with last -> nz 0x07; znz 0x14 with last.
REQ-038 SHALL cover: sixteen zeros, last on the 16th -> znz 0x78 with last; no nz output.
REQ-039 SHALL cover: seventeen zeros with last -> znz 0x78, then 0x00 with last.
REQ-040 SHALL cover: words 0x01..0x08, last on 0x08, nz_rdy_i held low for 10 cycles -> rdy_o low after the first nonzero is accepted; after release, nz 0x01..0x08 and znz 0xFF with last.
REQ-041 SHALL cover: rst_i pulsed after 5 of 8 words -> all valids low immediately; next block 0x05, 0x03 with last -> znz 0xC0 with last.
